// File: rtl/sobel_hls_udiv_13ns_8ns_13_seq_if.sv
// Operand/result handshake bundle for the sequential 13/8 unsigned divider.
interface sobel_hls_udiv_13ns_8ns_13_seq_if #(
  parameter int unsigned din0_WIDTH = 13,
  parameter int unsigned din1_WIDTH = 8,
  parameter int unsigned dout_WIDTH = 13
);
  logic                  din_valid;
  logic                  din_ready;
  logic [din0_WIDTH-1:0] din0;
  logic [din1_WIDTH-1:0] din1;
  logic                  dout_valid;
  logic                  dout_ready;
  logic [dout_WIDTH-1:0] quot;
  logic [din1_WIDTH-1:0] rem;
  logic                  div_by_zero;

  modport master (
    output din_valid, din0, din1, dout_ready,
    input  din_ready, dout_valid, quot, rem, div_by_zero
  );

  modport slave (
    input  din_valid, din0, din1, dout_ready,
    output din_ready, dout_valid, quot, rem, div_by_zero
  );
endinterface

// File: rtl/sobel_hls_udiv_13ns_8ns_13_seq.sv
// Sequential restoring unsigned divider (13-bit / 8-bit), one quotient bit per edge.
// Define SOBEL_HLS_UDIV_RADIX4_EN to retire two quotient bits per edge.
module sobel_hls_udiv_13ns_8ns_13_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 13,
  parameter int din1_WIDTH = 8,
  parameter int dout_WIDTH = 13
) (
  input  logic ap_clk,
  input  logic ap_rst,
  sobel_hls_udiv_13ns_8ns_13_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(dout_WIDTH);
`ifdef SOBEL_HLS_UDIV_RADIX4_EN
  localparam int unsigned CNT_INIT = (dout_WIDTH + 1) / 2 - 1;
  localparam bit          ODD      = (dout_WIDTH % 2) != 0;
`else
  localparam int unsigned CNT_INIT = dout_WIDTH - 1;
`endif

  if (dout_WIDTH != din0_WIDTH || ID < 0) begin : g_param_check
    $error("quotient width must equal dividend width and ID must be non-negative");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [din0_WIDTH-1:0] shreg_q, shreg_d;
  logic [din1_WIDTH-1:0] prem_q, prem_d;
  logic [din1_WIDTH-1:0] divisor_q, divisor_d;
  logic [dout_WIDTH-1:0] quot_q, quot_d;
  logic [din1_WIDTH-1:0] rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic                  din_ready_q, din_ready_d;
  logic                  dout_valid_q, dout_valid_d;
  logic [din1_WIDTH:0]   step_a;
`ifdef SOBEL_HLS_UDIV_RADIX4_EN
  logic [din1_WIDTH:0]   step_b;
`endif

  // One restoring step: returns {quotient bit, new partial remainder}.
  function automatic logic [din1_WIDTH:0] div_step(
    input logic [din1_WIDTH-1:0] p,
    input logic                  b,
    input logic [din1_WIDTH-1:0] d
  );
    logic [din1_WIDTH:0] trial;
    trial = {p, b};
    if (trial >= {1'b0, d})
      return {1'b1, din1_WIDTH'(trial - {1'b0, d})};
    else
      return {1'b0, trial[din1_WIDTH-1:0]};
  endfunction

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    shreg_d      = shreg_q;
    prem_d       = prem_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    dbz_d        = dbz_q;
    step_a       = '0;
`ifdef SOBEL_HLS_UDIV_RADIX4_EN
    step_b       = '0;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.din_valid) begin
          divisor_d = bus.din1;
          shreg_d   = bus.din0;
          prem_d    = '0;
          count_d   = CNT_W'(CNT_INIT);
          if (bus.din1 == '0) begin
            state_d = DONE;
            quot_d  = '1;
            rem_d   = bus.din0[din1_WIDTH-1:0];
            dbz_d   = 1'b1;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // Dividend bits leave at the top, quotient bits enter at the bottom.
`ifdef SOBEL_HLS_UDIV_RADIX4_EN
        step_a = div_step(prem_q, shreg_q[din0_WIDTH-1], divisor_q);
        if (ODD && count_q == CNT_W'(CNT_INIT)) begin
          shreg_d = {shreg_q[din0_WIDTH-2:0], step_a[din1_WIDTH]};
          prem_d  = step_a[din1_WIDTH-1:0];
        end else begin
          step_b  = div_step(step_a[din1_WIDTH-1:0], shreg_q[din0_WIDTH-2], divisor_q);
          shreg_d = {shreg_q[din0_WIDTH-3:0], step_a[din1_WIDTH], step_b[din1_WIDTH]};
          prem_d  = step_b[din1_WIDTH-1:0];
        end
`else
        step_a  = div_step(prem_q, shreg_q[din0_WIDTH-1], divisor_q);
        shreg_d = {shreg_q[din0_WIDTH-2:0], step_a[din1_WIDTH]};
        prem_d  = step_a[din1_WIDTH-1:0];
`endif
        if (count_q == '0) begin
          state_d = DONE;
          quot_d  = dout_WIDTH'(shreg_d);
          rem_d   = prem_d;
          dbz_d   = 1'b0;
        end else begin
          count_d = count_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (bus.dout_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    din_ready_d  = (state_d == IDLE);
    dout_valid_d = (state_d == DONE);
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      count_q      <= '0;
      shreg_q      <= '0;
      prem_q       <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      dbz_q        <= 1'b0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      shreg_q      <= shreg_d;
      prem_q       <= prem_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      dbz_q        <= dbz_d;
      din_ready_q  <= din_ready_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  assign bus.din_ready   = din_ready_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_sobel_hls_udiv_13ns_8ns_13_seq.sv
// Self-checking bench for the sequential 13/8 divider: table vectors, handshake
// corner cases, reset abort and a randomised scoreboard run.
module tb_sobel_hls_udiv_13ns_8ns_13_seq;

`ifdef SOBEL_HLS_UDIV_RADIX4_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 14;
`endif

  logic ap_clk = 1'b0;
  logic ap_rst;
  always #5 ap_clk = ~ap_clk;

  sobel_hls_udiv_13ns_8ns_13_seq_if bus_if ();

  sobel_hls_udiv_13ns_8ns_13_seq dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus_if)
  );

  typedef struct {
    logic [12:0] d0;
    logic [7:0]  d1;
    logic [12:0] q;
    logic [7:0]  r;
    logic        z;
  } res_t;

  res_t sb[$];
  res_t vt[10];
  int   passed = 0;
  int   total  = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic res_t model(input logic [12:0] d0, input logic [7:0] d1);
    res_t e;
    e.d0 = d0;
    e.d1 = d1;
    if (d1 == 8'd0) begin
      e.q = 13'd8191;
      e.r = d0[7:0];
      e.z = 1'b1;
    end else begin
      e.q = 13'(d0 / d1);
      e.r = 8'(d0 % d1);
      e.z = 1'b0;
    end
    return e;
  endfunction

  // Present operands, wait for acceptance, push the expectation on the accepting edge.
  task automatic issue(input res_t e);
    int k = 0;
    bus_if.din0      = e.d0;
    bus_if.din1      = e.d1;
    bus_if.din_valid = 1'b1;
    while (!bus_if.din_ready && k < 64) begin
      @(posedge ap_clk); #1; k++;
    end
    if (!bus_if.din_ready) chk("issue_timeout", 0, 1);
    @(posedge ap_clk);
    sb.push_back(e);
    #1;
    bus_if.din_valid = 1'b0;
    bus_if.din0      = 13'($urandom);
    bus_if.din1      = 8'($urandom);
  endtask

  // Edges from the accepting edge (which counts as 1) until dout_valid is seen.
  task automatic await_valid(output int n);
    n = 1;
    while (!bus_if.dout_valid && n < 64) begin
      @(posedge ap_clk); #1; n++;
    end
  endtask

  task automatic retire(input string tag, input int stall);
    res_t e;
    repeat (stall) begin @(posedge ap_clk); #1; end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_quot"}, bus_if.quot, e.q);
      chk({tag, "_rem"}, bus_if.rem, e.r);
      chk({tag, "_dbz"}, bus_if.div_by_zero, e.z);
      if (!e.z) begin
        chk({tag, "_identity"}, bus_if.quot * e.d1 + bus_if.rem, e.d0);
        chk({tag, "_rem_lt_div"}, longint'(bus_if.rem < e.d1), 1);
      end
    end
    bus_if.dout_ready = 1'b1;
    @(posedge ap_clk); #1;
    bus_if.dout_ready = 1'b0;
    chk({tag, "_release_valid_ready"}, {bus_if.dout_valid, bus_if.din_ready}, 2'b01);
  endtask

  task automatic run_op(input string tag, input res_t e, input int lat, input int stall);
    int n;
    issue(e);
    await_valid(n);
    if (lat > 0) chk({tag, "_latency"}, n, lat);
    if (!bus_if.dout_valid) begin
      chk({tag, "_valid_timeout"}, 0, 1);
      void'(sb.pop_front());
    end else begin
      retire(tag, stall);
    end
  endtask

  initial begin
    res_t e;
    int   n;
    logic saw_valid;

    // 9000 does not fit in 13 bits; 8000 = 40*200 covers the exact-multiple case.
    vt[0] = '{13'd8000, 8'd200, 13'd40,   8'd0,   1'b0};
    vt[1] = '{13'd8191, 8'd255, 13'd32,   8'd31,  1'b0};
    vt[2] = '{13'd4095, 8'd63,  13'd65,   8'd0,   1'b0};
    vt[3] = '{13'd0,    8'd7,   13'd0,    8'd0,   1'b0};
    vt[4] = '{13'd100,  8'd0,   13'd8191, 8'd100, 1'b1};
    vt[5] = '{13'd50,   8'd5,   13'd10,   8'd0,   1'b0};
    vt[6] = '{13'd8191, 8'd1,   13'd8191, 8'd0,   1'b0};
    vt[7] = '{13'd300,  8'd0,   13'd8191, 8'd44,  1'b1};
    vt[8] = '{13'd1234, 8'd255, 13'd4,    8'd214, 1'b0};
    vt[9] = '{13'd7,    8'd200, 13'd0,    8'd7,   1'b0};

    ap_rst            = 1'b1;
    bus_if.din_valid  = 1'b0;
    bus_if.dout_ready = 1'b0;
    bus_if.din0       = '0;
    bus_if.din1       = '0;
    repeat (3) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    chk("reset_din_ready", bus_if.din_ready, 1);
    chk("reset_dout_valid", bus_if.dout_valid, 0);
    chk("reset_quot", bus_if.quot, 0);
    chk("reset_rem", bus_if.rem, 0);
    chk("reset_dbz", bus_if.div_by_zero, 0);

    foreach (vt[i]) begin
      run_op($sformatf("vec%0d", i), vt[i], vt[i].z ? 1 : LAT, i % 3);
    end

    // Results must hold while the consumer stalls; operand noise must not be accepted.
    issue(vt[0]);
    await_valid(n);
    chk("hold_latency", n, LAT);
    for (int c = 0; c < 5; c++) begin
      bus_if.din_valid = ~bus_if.din_valid;
      bus_if.din0      = 13'($urandom);
      bus_if.din1      = 8'($urandom_range(1, 255));
      @(posedge ap_clk); #1;
      chk($sformatf("hold%0d_state", c),
          {bus_if.dout_valid, bus_if.din_ready, bus_if.div_by_zero}, 3'b100);
      chk($sformatf("hold%0d_quot", c), bus_if.quot, 40);
      chk($sformatf("hold%0d_rem", c), bus_if.rem, 0);
    end
    bus_if.din_valid = 1'b0;
    retire("hold", 0);

    // Reset in the middle of an iteration aborts the operation.
    issue(vt[2]);
    repeat (5) begin @(posedge ap_clk); #1; end
    ap_rst = 1'b1;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    sb.delete();
    chk("abort_din_ready", bus_if.din_ready, 1);
    chk("abort_dout_valid", bus_if.dout_valid, 0);
    chk("abort_quot", bus_if.quot, 0);
    chk("abort_rem", bus_if.rem, 0);
    chk("abort_dbz", bus_if.div_by_zero, 0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(posedge ap_clk); #1;
      saw_valid |= bus_if.dout_valid;
    end
    chk("abort_no_valid_pulse", saw_valid, 0);

    for (int i = 0; i < 1000; i++) begin
      e = model(13'($urandom_range(0, 8191)), 8'($urandom_range(1, 255)));
      run_op("rand", e, (i % 50 == 0) ? LAT : 0, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
